// File: rtl/enum_t.sv
// ---------------------------------------------------------------
// enum_t : command and status types shared with the i2c master engine
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package enum_t;

  typedef enum logic [2:0] {
    EN_STOP,
    EN_START,
    EN_WR,
    EN_RD_ACK,
    EN_RD_NACK
  } en_t;

  typedef enum logic [2:0] {
    STOP,
    START,
    WR,
    RD,
    ERR
  } i2c_t;

endpackage

`default_nettype wire

// File: rtl/i2c_arb_pkg.sv
// ---------------------------------------------------------------
// i2c_arb_pkg : arbiter state type and shared constants
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam enum_t::en_t EN_PARK   = enum_t::EN_STOP;
  localparam int          N_REQ_MAX = 8;

endpackage

`default_nettype wire

// File: rtl/i2c_arbiter_rr_pick.sv
// ---------------------------------------------------------------
// rr_pick : combinational round-robin picker, first req at/after ptr
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PW    = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [PW-1:0]    idx_o,
  output logic             valid_o
);

  logic [PW-1:0] cand;

  always_comb begin
    pick_o  = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PW'((int'(ptr_i) + i) % N_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o      = 1'b1;
        pick_o[cand] = 1'b1;
        idx_o        = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_arbiter.sv
// ---------------------------------------------------------------
// i2c_arbiter : round-robin session arbiter in front of one i2c engine
// Optional watchdog abort: define I2C_ARB_WATCHDOG_EN.   Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*8-1:0]   req_data,
  input  enum_t::en_t          req_en [N_REQ],
  output logic [N_REQ-1:0]     grant,
  output enum_t::i2c_t         st_out,
  output logic [7:0]           rd_data,
  output logic [7:0]           i2c_data,
  output enum_t::en_t          i2c_en,
  input  enum_t::i2c_t         i2c_st,
  input  logic [7:0]           i2c_rdata,
  output logic                 busy,
  output logic [N_REQ-1:0]     timeout
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] req_elig;
  logic [N_REQ-1:0] pick;
  logic [PW-1:0]    pick_idx;
  logic             pick_valid;
  logic             close;

`ifdef I2C_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             abort_q, abort_d;
  enum_t::i2c_t     st_prev_q;
  logic [N_REQ-1:0] timeout_q, timeout_d;

  // A timed-out requester is not eligible again until it has dropped req.
  assign req_elig = req & ~timeout_q;
  assign timeout  = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT > 0);
  assign req_elig   = req;
  assign timeout    = '0;
`endif

  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_rr_pick (
    .req_i   (req_elig),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    close   = 1'b0;
`ifdef I2C_ARB_WATCHDOG_EN
    cnt_d     = '0;
    abort_d   = abort_q;
    timeout_d = timeout_q & req;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWN;
          grant_d = pick;
          owner_d = pick_idx;
        end
      end
      OWN: begin
`ifdef I2C_ARB_WATCHDOG_EN
        if (i2c_st != st_prev_q) begin
          cnt_d = '0;
        end else if (abort_q) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TIMEOUT - 1)) abort_d = 1'b1;
        end
`endif
        if (!req[owner_q]) begin
          close = 1'b1;
`ifdef I2C_ARB_WATCHDOG_EN
        end else if (abort_q && (i2c_st == enum_t::STOP)) begin
          close              = 1'b1;
          timeout_d[owner_q] = 1'b1;
`endif
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (close) begin
      state_d = RELEASE;
      grant_d = '0;
      ptr_d   = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);
`ifdef I2C_ARB_WATCHDOG_EN
      abort_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef I2C_ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      st_prev_q <= enum_t::STOP;
      timeout_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      st_prev_q <= i2c_st;
      timeout_q <= timeout_d;
    end
  end
`endif

  // Engine-facing mux keys off the registered grant so it cannot glitch mid-cycle.
  always_comb begin
    i2c_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) i2c_data = i2c_data | req_data[8*k +: 8];
    end
    i2c_en = (|grant_q) ? req_en[owner_q] : EN_PARK;
`ifdef I2C_ARB_WATCHDOG_EN
    if (abort_q) i2c_en = EN_PARK;
`endif
  end

  assign grant   = grant_q;
  assign busy    = |grant_q;
  assign st_out  = i2c_st;
  assign rd_data = i2c_rdata;

endmodule

`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
// ---------------------------------------------------------------
// tb_i2c_arbiter : directed + randomized self-checking bench for i2c_arbiter
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_i2c_arbiter;

  localparam int N  = 3;
  localparam int TO = 100;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req;
  logic [N*8-1:0]     req_data;
  enum_t::en_t        req_en [N];
  logic [N-1:0]       grant;
  enum_t::i2c_t       st_out;
  logic [7:0]         rd_data;
  logic [7:0]         i2c_data;
  enum_t::en_t        i2c_en;
  enum_t::i2c_t       i2c_st;
  logic [7:0]         i2c_rdata;
  logic               busy;
  logic [N-1:0]       timeout;

  int n_tests;
  int n_fail;
  bit chk_on;

  // Reference model: current owner (-1 none), guard cycles left, rr pointer.
  int m_owner;
  int m_guard;
  int m_ptr;

  i2c_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .req_en    (req_en),
    .grant     (grant),
    .st_out    (st_out),
    .rd_data   (rd_data),
    .i2c_data  (i2c_data),
    .i2c_en    (i2c_en),
    .i2c_st    (i2c_st),
    .i2c_rdata (i2c_rdata),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_guard = 0;
    m_ptr   = 0;
  endtask

  // A session ends when the owner's req is seen low; then one guard cycle,
  // then the first requester at/after the pointer wins.
  task automatic model_edge(input logic [N-1:0] r);
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_guard = 1;
      end
    end else if (m_guard > 0) begin
      m_guard--;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_owner < 0 && r[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
      end
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] eg;
    logic [7:0]   ed;
    enum_t::en_t  ee;
    eg = '0;
    ed = 8'h00;
    ee = enum_t::EN_STOP;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ed = req_data[8*m_owner +: 8];
      ee = req_en[m_owner];
    end
    check_eq("grant", 32'(grant), 32'(eg));
    check_eq("busy", 32'(busy), 32'(m_owner >= 0));
    check_eq("i2c_data", 32'(i2c_data), 32'(ed));
    check_eq("i2c_en", 32'(i2c_en), 32'(ee));
    check_eq("st_out", 32'(st_out), 32'(i2c_st));
    check_eq("rd_data", 32'(rd_data), 32'(i2c_rdata));
    check_eq("timeout", 32'(timeout), 32'(0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(req);
    #1;
    if (chk_on) compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    n_tests   = 0;
    n_fail    = 0;
    chk_on    = 1'b1;
    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    for (int k = 0; k < N; k++) req_en[k] = enum_t::EN_WR;
    i2c_st    = enum_t::STOP;
    i2c_rdata = 8'h00;
    model_reset();

    // Reset state, idle for 10 cycles
    do_reset();
    check_eq("rst_grant", 32'(grant), 32'(0));
    check_eq("rst_en", 32'(i2c_en), 32'(enum_t::EN_STOP));
    repeat (10) step();

    // Single requester session
    req_data[7:0] = 8'hD0;
    req = 3'b001;
    step();
    check_eq("s0_grant", 32'(grant), 32'(3'b001));
    check_eq("s0_data", 32'(i2c_data), 32'(8'hD0));
    repeat (33) step();
    req = 3'b000;
    step();
    check_eq("s0_release", 32'(grant), 32'(0));
    repeat (2) step();

    // Simultaneous requests after reset: pointer at 0 picks requester 0
    do_reset();
    req = 3'b011;
    step();
    check_eq("both_first", 32'(grant), 32'(3'b001));
    repeat (4) step();
    req = 3'b010;
    step();
    check_eq("handoff_idle1", 32'(grant), 32'(0));
    step();
    check_eq("handoff_idle2", 32'(grant), 32'(0));
    step();
    check_eq("handoff_grant", 32'(grant), 32'(3'b010));

    // No preemption: requester 0 rises while 1 owns
    req_en[1] = enum_t::EN_RD_ACK;
    req = 3'b011;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("hold_grant", 32'(grant), 32'(3'b010));
      check_eq("hold_en", 32'(i2c_en), 32'(enum_t::EN_RD_ACK));
    end
    req = 3'b001;
    repeat (3) step();
    check_eq("next_rr", 32'(grant), 32'(3'b001));

    // Asynchronous reset mid-session
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("arst_grant", 32'(grant), 32'(0));
    check_eq("arst_busy", 32'(busy), 32'(0));
    check_eq("arst_en", 32'(i2c_en), 32'(enum_t::EN_STOP));
    req = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step();

`ifdef I2C_ARB_WATCHDOG_EN
    // Watchdog: engine status frozen at WR
    chk_on = 1'b0;
    i2c_st = enum_t::WR;
    do_reset();
    step();
    req_en[0] = enum_t::EN_WR;
    req = 3'b001;
    step();
    check_eq("wd_grant", 32'(grant), 32'(3'b001));
    n = 0;
    while (i2c_en != enum_t::EN_STOP && n < 2 * TO) begin
      step();
      n++;
    end
    check_eq("wd_cycles", 32'(n), 32'(TO));
    check_eq("wd_hold", 32'(grant), 32'(3'b001));
    i2c_st = enum_t::STOP;
    step();
    check_eq("wd_drop", 32'(grant), 32'(0));
    check_eq("wd_flag", 32'(timeout), 32'(3'b001));
    repeat (3) step();
    check_eq("wd_no_regrant", 32'(grant), 32'(0));
    check_eq("wd_flag_held", 32'(timeout), 32'(3'b001));
    req = 3'b000;
    step();
    check_eq("wd_clear", 32'(timeout), 32'(0));
    do_reset();
    chk_on = 1'b1;
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 7) == 0) req[k] = ~req[k];
        req_en[k] = enum_t::en_t'($urandom_range(0, 4));
      end
      req_data  = N*8'($urandom());
      i2c_st    = enum_t::i2c_t'($urandom_range(0, 4));
      i2c_rdata = 8'($urandom());
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
